// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer APB register block:
// register addresses, control/status bit positions, the TCR write mask,
// the APB handshake state enum and the status-flag update helper.
package timer_pkg;

   localparam logic [2:0] ADDR_TDR  = 3'd0;
   localparam logic [2:0] ADDR_TCR  = 3'd1;
   localparam logic [2:0] ADDR_TSR  = 3'd2;
   localparam logic [2:0] ADDR_TCNT = 3'd3;
   localparam logic [2:0] ADDR_TIER = 3'd4;

   localparam int unsigned TCR_LOAD_BIT = 32'd7;
   localparam int unsigned TCR_DIR_BIT  = 32'd5;
   localparam int unsigned TCR_EN_BIT   = 32'd4;
   localparam int unsigned TCR_CKS_MSB  = 32'd1;
   localparam int unsigned TCR_CKS_LSB  = 32'd0;

   localparam int unsigned TSR_OVF_BIT  = 32'd0;
   localparam int unsigned TSR_UDF_BIT  = 32'd1;

   // Only bits 7, 5, 4, 1 and 0 of TCR exist; the rest always read 0.
   localparam logic [7:0] TCR_WMASK = 8'hB3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   // Write-1-to-clear flag update; a set event in the same cycle wins.
   function automatic logic tsr_flag_next(input logic flag, input logic set, input logic clr);
      return set | (flag & ~clr);
   endfunction

endpackage

// File: rtl/timer_apb_fsm.sv
// APB handshake sequencer for the timer register block.
// Tracks IDLE/SETUP/ACCESS, inserts WAIT_CYCLES wait states in the access
// phase and raises pready for exactly one cycle. access_stb marks the cycle
// in which the register block commits a write or returns read data.
module timer_apb_fsm
   import timer_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 32'd1
) (
   input  logic clk,
   input  logic rst,
   input  logic psel,
   input  logic penable,
   output logic pready,
   output logic access_stb
);

   localparam logic [2:0] WAIT_INIT = WAIT_CYCLES[2:0];

   apb_state_e state_r;
   apb_state_e state_s;
   logic [2:0] cnt_r;
   logic [2:0] cnt_s;
   logic       pready_r;
   logic       pready_s;

   // Next-state and wait-counter logic; dropping psel aborts the transfer.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (!psel) begin
               state_s = ST_IDLE;
            end else if (penable) begin
               state_s = ST_ACCESS;
               cnt_s   = WAIT_INIT;
            end else begin
               state_s = ST_SETUP;
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_s = ST_IDLE;
            end else if (cnt_r != 3'd0) begin
               cnt_s = cnt_r - 3'd1;
            end else begin
               // This is the pready cycle; the next SETUP may follow at once.
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
         end
      endcase
   end

   // pready is registered: it is high exactly while ACCESS has no wait left.
   always_comb begin
      pready_s = (state_s == ST_ACCESS) && (cnt_s == 3'd0);
   end

   // State, wait counter and pready flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 3'd0;
         pready_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         pready_r <= pready_s;
      end
   end

   assign pready     = pready_r;
   assign access_stb = pready_r & psel & penable;

endmodule

// File: rtl/timer_apb_regs.sv
// APB register block for the 8-bit timer: TDR, TCR, TSR (W1C), TCNT (RO).
// Optional feature macro TIMER_IRQ_EN adds TIER at 0x04 and a registered irq;
// without it 0x04 is an invalid address and irq is tied low.
module timer_apb_regs
   import timer_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 32'd1,
   parameter int unsigned ADDR_W      = 32'd8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [7:0]        pwdata,
   output logic [7:0]        prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [7:0]        cnt_in,
   input  logic              ovf_set,
   input  logic              udf_set,
   output logic [7:0]        tdr,
   output logic              load,
   output logic              dir_down,
   output logic              cnt_en,
   output logic [1:0]        cks,
   output logic              irq
);

   logic       pready_s;
   logic       access_stb_s;
   logic       addr_ok_s;
   logic [7:0] rdata_s;
   logic       err_s;
   logic       wr_s;
   logic [7:0] tdr_r;
   logic [7:0] tcr_r;
   logic       ovf_r;
   logic       udf_r;

   timer_apb_fsm #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .pready     (pready_s),
      .access_stb (access_stb_s)
   );

   // Only the low three address bits decode; anything above must be zero.
   assign addr_ok_s = ((paddr >> 32'd3) == '0);

`ifdef TIMER_IRQ_EN
   logic [1:0] tier_r;
   logic       irq_r;
`endif

   // Address decode: read data and error response for the current access.
   always_comb begin
      rdata_s = 8'h00;
      err_s   = 1'b0;
      if (!addr_ok_s) begin
         err_s = 1'b1;
      end else begin
         case (paddr[2:0])
            ADDR_TDR:  rdata_s = tdr_r;
            ADDR_TCR:  rdata_s = tcr_r;
            ADDR_TSR:  rdata_s = {6'b000000, udf_r, ovf_r};
            ADDR_TCNT: begin
               rdata_s = cnt_in;
               err_s   = pwrite;
            end
`ifdef TIMER_IRQ_EN
            ADDR_TIER: rdata_s = {6'b000000, tier_r};
`endif
            default:   err_s = 1'b1;
         endcase
      end
   end

   assign pready  = pready_s;
   assign pslverr = pready_s ? err_s : 1'b0;
   assign prdata  = (pready_s && !pwrite && !err_s) ? rdata_s : 8'h00;
   assign wr_s    = access_stb_s & pwrite & ~err_s;

   // TDR and TCR storage; TCR keeps only its implemented bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdr_r <= 8'h00;
         tcr_r <= 8'h00;
      end else begin
         if (wr_s && (paddr[2:0] == ADDR_TDR)) begin
            tdr_r <= pwdata;
         end else begin
            tdr_r <= tdr_r;
         end
         if (wr_s && (paddr[2:0] == ADDR_TCR)) begin
            tcr_r <= pwdata & TCR_WMASK;
         end else begin
            tcr_r <= tcr_r;
         end
      end
   end

   // TSR flags: set by counter events, cleared by writing 1, set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         ovf_r <= tsr_flag_next(ovf_r, ovf_set,
                                wr_s && (paddr[2:0] == ADDR_TSR) && pwdata[TSR_OVF_BIT]);
         udf_r <= tsr_flag_next(udf_r, udf_set,
                                wr_s && (paddr[2:0] == ADDR_TSR) && pwdata[TSR_UDF_BIT]);
      end
   end

`ifdef TIMER_IRQ_EN
   // TIER storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tier_r <= 2'b00;
      end else if (wr_s && (paddr[2:0] == ADDR_TIER)) begin
         tier_r <= pwdata[1:0];
      end else begin
         tier_r <= tier_r;
      end
   end

   // Interrupt: enabled status flags, registered one cycle behind TSR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= (ovf_r & tier_r[0]) | (udf_r & tier_r[1]);
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

   assign tdr      = tdr_r;
   assign load     = tcr_r[TCR_LOAD_BIT];
   assign dir_down = tcr_r[TCR_DIR_BIT];
   assign cnt_en   = tcr_r[TCR_EN_BIT];
   assign cks      = tcr_r[TCR_CKS_MSB:TCR_CKS_LSB];

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
APB slave register block for the 8-bit timer IP. It sits directly downstream of the CPU bus functional model and upstream of the timer counter core. It decodes APB accesses to TDR, TCR, TSR and TCNT, and drives control levels to the counter. It captures overflow/underflow events from the counter into write-1-to-clear status flags.

Parameters:
WAIT_CYCLES, 1, number of extra cycles pready is held low in the access phase (0..7)
ADDR_W, 8, APB address width; only the low 3 bits are decoded, all upper bits must be 0

Ports:
clk  in  1  system/APB clock
rst  in  1  asynchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data, valid when pready=1 and pwrite=0
pready  out  1  transfer complete
pslverr  out  1  error response, valid with pready
cnt_in  in  8  current counter value, from counter core
ovf_set  in  1  one-cycle overflow pulse, from counter core
udf_set  in  1  one-cycle underflow pulse, from counter core
tdr  out  8  TDR value to counter (load value)
load  out  1  TCR[7]
dir_down  out  1  TCR[5]: 1 = count down
cnt_en  out  1  TCR[4]
cks  out  2  TCR[1:0] clock-select
irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset (async, rst=1): TDR=0x00, TCR=0x00, TSR=0x00, prdata=0x00, pready=0, pslverr=0, irq=0, FSM=IDLE.
- Address map: 0x00 TDR RW; 0x01 TCR RW (bits 7,5,4,1,0 writable, others read 0); 0x02 TSR (bit0 OVF, bit1 UDF, W1C, others read 0); 0x03 TCNT RO = cnt_in.
- Any other address is invalid: pslverr=1 with pready, write ignored, prdata=0x00.
- Writes to 0x03 also return pslverr=1 and have no effect.
- FSM states:
  - IDLE: go to SETUP when psel&!penable.
  - SETUP: go to ACCESS when psel&penable; a wait counter loads WAIT_CYCLES.
  - ACCESS: while counter>0, decrement with pready=0. At counter==0, assert pready=1 for exactly one cycle, perform the write / drive prdata / drive pslverr in that cycle, then return to IDLE.
  - psel dropping in SETUP or ACCESS: return to IDLE with no register update.
- Latency: pready rises WAIT_CYCLES+1 cycles after the first penable cycle. With WAIT_CYCLES=0 there is no wait state beyond the standard access phase.
- prdata and pslverr are 0 whenever pready=0.
- Status flags:
  - OVF is set on ovf_set and UDF on udf_set.
  - Writing 1 to a TSR bit clears it; writing 0 leaves it unchanged.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Control outputs are combinational copies of the register bits, updated the cycle after the write completes.
- Back-to-back transfers: a new SETUP is accepted in the cycle immediately after the pready cycle.

Optional Feature:
- Macro TIMER_IRQ_EN.
- Defined:
  - Adds TIER at 0x04 (bit0 OVF_IE, bit1 UDF_IE, reset 0, RW).
  - irq = (OVF&OVF_IE)|(UDF&UDF_IE), registered, one-cycle lag.
- Undefined:
  - 0x04 is an invalid address (pslverr=1).
  - irq is tied to 0.

Decomposition:
- Shared package timer_pkg holds:
  - address constants ADDR_TDR/TCR/TSR/TCNT/TIER
  - TCR/TSR bit-index constants
  - TCR write mask 8'hB3
  - the FSM state enum
- One natural sub-module: timer_apb_fsm (IDLE/SETUP/ACCESS plus wait counter, producing pready and an access strobe). Register storage and decode stay in the top.

Test Plan:
- Reset then read 0x00 -> prdata=0x00, pslverr=0. Read 0x01 and 0x02 -> 0x00.
- Write TDR=0xA5, read 0x00 -> 0xA5. Repeat 50 random values; every readback equals the written value.
- Write TCR=0xFF -> readback 0xB3; load=1, dir_down=1, cnt_en=1, cks=2'b11.
- Pulse ovf_set -> TSR reads 0x01. Write TSR=0x01 in the same cycle as a new ovf_set pulse -> TSR still 0x01. Write 0x01 again -> 0x00.
- Read 0x07, and write 0x03 with pwdata 0x55 -> pslverr=1 with pready; TCNT still equals cnt_in.
- WAIT_CYCLES=3: measure penable rise to pready rise -> 4 cycles. Assert rst mid-ACCESS -> pready=0 immediately, TDR=0x00.
